// File: rtl/ram_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_write_arbiter_if
//   Bundles the two requester handshakes, the re-clear request and the RAM
//   write-port outputs of ram_write_arbiter.
//
//   slave  : the arbiter side (takes requests, drives readies and RAM port)
//   master : the requester/RAM side (drives requests, observes the rest)
//
//   clear_req              request to re-clear the whole RAM (one cycle)
//   reqN_valid/addr/data   requester N write request
//   reqN_ready             requester N accepted this cycle (combinational)
//   w_addr/w_data          registered RAM write address/data
//   write_enable           registered RAM write strobe
//   init_done              high while the RAM holds valid contents
// ----------------------------------------------------------------------------
interface ram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  clear_req;
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  write_enable;
  logic                  init_done;

  modport slave (
    input  clear_req,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output w_addr, w_data, write_enable, init_done
  );

  modport master (
    output clear_req,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  w_addr, w_data, write_enable, init_done
  );
endinterface

// File: rtl/ram_write_arbiter.sv
// ----------------------------------------------------------------------------
// ram_write_arbiter
//   Write-port controller for a RAM with one synchronous write port. After
//   reset (or a clear_req) it writes zero to every address, then shares the
//   write port between two requesters with round-robin arbitration.
//
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : ram_write_arbiter_if.slave (requests, readies, RAM write port,
//          init_done)
// ----------------------------------------------------------------------------
module ram_write_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_write_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_prio, w_prio_nxt;      // 0: requester 0 favoured
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_w_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_w_data, w_data_nxt;
  logic                  w_ready0, w_ready1;
  logic                  w_hs0, w_hs1;

  always_comb begin
    // NOTE: every signal written here gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_prio_nxt  = r_prio;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_w_addr;
    w_data_nxt  = r_w_data;

    // A requester is ready unless the other one is both valid and favoured,
    // so a lone requester never waits. A pending clear blocks both.
    w_ready0 = (r_state == ST_RUN) && !bus.clear_req &&
               (!bus.req1_valid || (r_prio == 1'b0));
    w_ready1 = (r_state == ST_RUN) && !bus.clear_req &&
               (!bus.req0_valid || (r_prio == 1'b1));
    w_hs0    = bus.req0_valid && w_ready0;
    w_hs1    = bus.req1_valid && w_ready1;

    case (r_state)
      ST_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        w_cnt_nxt  = r_cnt + 1'b1;   // wraps to 0 after the last address
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else if (w_hs0) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = bus.req0_addr;
          w_data_nxt = bus.req0_data;
          w_prio_nxt = 1'b1;
        end else if (w_hs1) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = bus.req1_addr;
          w_data_nxt = bus.req1_data;
          w_prio_nxt = 1'b0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_CLEAR;
      r_cnt    <= '0;
      r_prio   <= 1'b0;
      r_we     <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_prio   <= w_prio_nxt;
      r_we     <= w_we_nxt;
      r_w_addr <= w_addr_nxt;
      r_w_data <= w_data_nxt;
    end
  end

  assign bus.req0_ready   = w_ready0;
  assign bus.req1_ready   = w_ready1;
  assign bus.w_addr       = r_w_addr;
  assign bus.w_data       = r_w_data;
  assign bus.write_enable = r_we;
  // The single-bit state flop is itself the RUN indicator.
  assign bus.init_done    = (r_state == ST_RUN);

endmodule

// File: tb/tb_ram_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_write_arbiter
//   Self-checking bench: a transaction-level model of the arbiter (clear
//   progress counter, favoured requester, expected RAM port) is compared with
//   the DUT every cycle, a behavioural RAM is written from the DUT port, and
//   directed scenarios pin the model with literal expectations before a
//   randomized run.
// ----------------------------------------------------------------------------
module tb_ram_write_arbiter;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  ram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner of one arbitration round: -1 none, 0 or 1.
  function automatic int winner(input logic v0, input logic v1, input int fav);
    if (v0 && v1) return fav;
    if (v0)       return 0;
    if (v1)       return 1;
    return -1;
  endfunction

  // Behavioural RAM driven by the DUT write port.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hFF;
    end else if (bus.write_enable) begin
      ram[bus.w_addr] <= bus.w_data;
    end
  end

  // Reference model
  bit            started    = 1'b0;
  bit            m_clearing = 1'b1;   // zero-fill in progress
  int            m_clr_addr = 0;      // next address to zero
  int            m_fav      = 0;      // requester that wins a tie
  bit            m_we       = 1'b0;
  int            m_addr     = 0;
  int            m_data     = 0;
  bit            m_init     = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];

  always @(posedge clk) begin : model
    int w;
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    end else if (m_we) begin
      m_mem[m_addr] = m_data[DW-1:0];
    end

    if (rst) begin
      m_clearing = 1'b1; m_clr_addr = 0; m_fav = 0;
      m_we = 1'b0; m_addr = 0; m_data = 0; m_init = 1'b0;
    end else if (m_clearing) begin
      m_we = 1'b1; m_addr = m_clr_addr; m_data = 0;
      if (m_clr_addr == DEPTH - 1) begin
        m_clearing = 1'b0; m_clr_addr = 0; m_init = 1'b1;
      end else begin
        m_clr_addr++;
      end
    end else if (bus.clear_req) begin
      m_clearing = 1'b1; m_clr_addr = 0; m_init = 1'b0; m_we = 1'b0;
    end else begin
      w = winner(bus.req0_valid, bus.req1_valid, m_fav);
      if (w == 0) begin
        m_we = 1'b1; m_addr = int'(bus.req0_addr); m_data = int'(bus.req0_data); m_fav = 1;
      end else if (w == 1) begin
        m_we = 1'b1; m_addr = int'(bus.req1_addr); m_data = int'(bus.req1_data); m_fav = 0;
      end else begin
        m_we = 1'b0;
      end
    end
    started = 1'b1;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("write_enable", {31'b0, bus.write_enable}, {31'b0, m_we});
      check("w_addr", {29'b0, bus.w_addr}, m_addr);
      check("w_data", {24'b0, bus.w_data}, m_data);
      check("init_done", {31'b0, bus.init_done}, {31'b0, m_init});
      check("req0_ready", {31'b0, bus.req0_ready},
            {31'b0, !m_clearing && !bus.clear_req &&
                    winner(1'b1, bus.req1_valid, m_fav) == 0});
      check("req1_ready", {31'b0, bus.req1_ready},
            {31'b0, !m_clearing && !bus.clear_req &&
                    winner(bus.req0_valid, 1'b1, m_fav) == 1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.clear_req  = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int i0, i1, n, guard;
    int grants[$];

    // Reset with the RAM pre-loaded to 0xFF.
    drive_idle();
    tick(); tick();
    check("rst write_enable", {31'b0, bus.write_enable}, 0);
    check("rst w_addr", {29'b0, bus.w_addr}, 0);
    check("rst w_data", {24'b0, bus.w_data}, 0);
    check("rst init_done", {31'b0, bus.init_done}, 0);
    check("rst req0_ready", {31'b0, bus.req0_ready}, 0);
    check("rst req1_ready", {31'b0, bus.req1_ready}, 0);
    preload = 1'b0;
    rst     = 1'b0;

    // Clear sequence: init_done after the 8th edge, last address 7.
    repeat (DEPTH) tick();
    check("clear init_done", {31'b0, bus.init_done}, 1);
    check("clear last addr", {29'b0, bus.w_addr}, DEPTH - 1);
    check("clear last we", {31'b0, bus.write_enable}, 1);
    tick();
    check("idle we", {31'b0, bus.write_enable}, 0);
    for (int i = 0; i < DEPTH; i++) check("cleared ram", {24'b0, ram[i]}, 0);

    // Single requester 0 write.
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 8'hA5;
    #1;
    check("single req0_ready", {31'b0, bus.req0_ready}, 1);
    tick();
    check("single we", {31'b0, bus.write_enable}, 1);
    check("single w_addr", {29'b0, bus.w_addr}, 3);
    check("single w_data", {24'b0, bus.w_data}, 8'hA5);
    bus.req0_valid = 1'b0;

    // Lone requester 1 for three back-to-back cycles.
    for (int k = 0; k < 3; k++) begin
      bus.req1_valid = 1'b1; bus.req1_addr = AW'(5 + k); bus.req1_data = DW'(8'h51 + k);
      #1;
      check("b2b req1_ready", {31'b0, bus.req1_ready}, 1);
      tick();
      check("b2b we", {31'b0, bus.write_enable}, 1);
      check("b2b w_addr", {29'b0, bus.w_addr}, 5 + k);
      if (k == 0) check("single ram[3]", {24'b0, ram[3]}, 8'hA5);
    end
    bus.req1_valid = 1'b0;

    // Contention: both hold valid until their four writes are accepted.
    i0 = 0; i1 = 0;
    for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
      bus.req0_valid = (i0 < 4); bus.req0_addr = AW'(i0);     bus.req0_data = DW'(8'h10 + i0);
      bus.req1_valid = (i1 < 4); bus.req1_addr = AW'(4 + i1); bus.req1_data = DW'(8'h20 + i1);
      #1;
      if (bus.req0_valid && bus.req0_ready) begin grants.push_back(0); i0++; end
      else if (bus.req1_valid && bus.req1_ready) begin grants.push_back(1); i1++; end
      tick();
    end
    drive_idle();
    check("contention done", {31'b0, (i0 == 4 && i1 == 4)}, 1);
    check("contention grants", grants.size(), 8);
    for (int j = 0; j < grants.size(); j++) check("grant order", grants[j], j % 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("contention ram req0", {24'b0, ram[i]}, 8'h10 + i);
      check("contention ram req1", {24'b0, ram[4 + i]}, 8'h20 + i);
    end

    // Clear collision with requester 1.
    bus.clear_req = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 8'h99;
    #1;
    check("collision req1_ready", {31'b0, bus.req1_ready}, 0);
    tick();
    bus.clear_req = 1'b0;
    check("collision we", {31'b0, bus.write_enable}, 0);
    check("collision init_done", {31'b0, bus.init_done}, 0);
    n = 0; guard = 0;
    while (!bus.init_done && guard < 30) begin
      tick(); guard++;
      if (bus.write_enable && bus.w_data == 0) n++;
    end
    check("reclear finished", {31'b0, bus.init_done}, 1);
    check("reclear zero writes", n, DEPTH);
    #1;
    check("post-clear req1_ready", {31'b0, bus.req1_ready}, 1);
    tick();
    check("post-clear w_addr", {29'b0, bus.w_addr}, 2);
    check("post-clear w_data", {24'b0, bus.w_data}, 8'h99);
    drive_idle();

    // Reset in the middle of a clear.
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    guard = 0;
    while (!(bus.write_enable && bus.w_addr == 3'd5) && guard < 30) begin
      tick(); guard++;
    end
    check("reached addr 5", {29'b0, bus.w_addr}, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst we", {31'b0, bus.write_enable}, 0);
    check("midrst w_addr", {29'b0, bus.w_addr}, 0);
    check("midrst init_done", {31'b0, bus.init_done}, 0);
    n = 0; guard = 0;
    while (!bus.init_done && guard < 30) begin
      tick(); guard++;
      if (bus.write_enable) begin
        check("restart addr", {29'b0, bus.w_addr}, n);
        n++;
      end
    end
    check("restart writes", n, DEPTH);

    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 400; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.clear_req  = ($urandom_range(0, 39) == 0);
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_addr  = AW'($urandom);
      bus.req0_data  = DW'($urandom);
      bus.req1_addr  = AW'($urandom);
      bus.req1_data  = DW'($urandom);
      tick();
    end
    rst = 1'b0;
    drive_idle();
    tick(); tick();
    for (int i = 0; i < DEPTH; i++) check("final ram", {24'b0, ram[i]}, {24'b0, m_mem[i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_write_arbiter.md
# ram_write_arbiter

Write-port controller for the team's 3-port RAM (two asynchronous read ports, one synchronous write port). After reset it sequences a full clear of the memory, then shares the single write port between two requesters using round-robin arbitration and valid/ready handshakes. It drives the RAM's `w_addr`, `w_data` and `write_enable` directly from registers. The read ports are untouched; consumers use `init_done` to know when read data is meaningful.

## Interface
- `ADDR_WIDTH`, default 3: RAM address width; the RAM depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: RAM word width.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clear_req`  in  1  single-cycle request to re-clear the whole RAM; only sampled in RUN.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  ADDR_WIDTH  requester 0 write address.
- `req0_data`  in  DATA_WIDTH  requester 0 write data.
- `req0_ready`  out  1  requester 0 write is accepted this cycle (combinational).
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: the same four signals for requester 1.
- `w_addr`  out  ADDR_WIDTH  to the RAM `w_addr` (registered).
- `w_data`  out  DATA_WIDTH  to the RAM `w_data` (registered).
- `write_enable`  out  1  to the RAM `write_enable` (registered).
- `init_done`  out  1  high while in RUN (registered).

## Operation
- The state machine has two states, CLEAR and RUN. Reset forces CLEAR, `cnt`=0 and `prio`=0 (requester 0 favoured).
- Behaviour in CLEAR:
  - Each cycle registers `write_enable`=1, `w_addr`=`cnt` and `w_data`=0, then increments `cnt`.
  - When `cnt`=2**ADDR_WIDTH-1 is issued, the next state is RUN and `cnt` wraps to 0.
  - Both readies are held low.
- Readiness in RUN:
  - `req0_ready` = `!clear_req && (!req1_valid || prio==0)`.
  - `req1_ready` = `!clear_req && (!req0_valid || prio==1)`.
  - At most one ready is high in any cycle. Readies depend on the valids, so a requester must not make its valid depend on its ready.
- A handshake is `valid && ready` at a rising edge. On a handshake, that requester's addr/data are registered onto `w_addr`/`w_data` with `write_enable`=1. On a handshake, `prio` is set to point at the other requester.
- With no handshake in RUN, `write_enable` is registered to 0 and `w_addr`/`w_data` hold their previous values.
- `prio` changes only on a handshake. A lone requester never waits, whatever the value of `prio`.
- If `clear_req` is high in RUN, no handshake occurs that cycle and the next state is CLEAR with `cnt`=0. `clear_req` is ignored while in CLEAR.
- If `rst` is asserted mid-clear, the clear restarts at address 0. If `rst` is asserted in RUN, in-flight handshakes are discarded.
- Arithmetic: `cnt` is ADDR_WIDTH bits wide and wraps naturally. There are no partial or out-of-range addresses.

## Timing
- Reset values: `write_enable`=0, `w_addr`=0, `w_data`=0, `init_done`=0, `req0_ready`=`req1_ready`=0.
- Clear sequence: let edge E be the first rising edge with `rst` low.
  - `write_enable` is high in the cycles after edges E through E+2**ADDR_WIDTH-1, with `w_addr` running 0..2**ADDR_WIDTH-1.
  - `init_done` rises at edge E+2**ADDR_WIDTH-1, and readies may be high from that cycle.
- Write latency: a handshake at edge k produces `write_enable`=1 after edge k. The RAM commits the word at edge k+1, and asynchronous reads show it after edge k+1.
- Throughput is one write per cycle. Under continuous contention, the requesters alternate every cycle.
- `init_done` falls on the edge after `clear_req` is sampled. A re-clear also takes 2**ADDR_WIDTH cycles.

## Test plan
- **Reset and clear:** pre-load the RAM with 0xFF, then pulse `rst` for 1 cycle. Required: 8 consecutive writes of 0x00 to addresses 0..7, `init_done` high 8 edges after `rst` falls, and both read ports return 0x00 at all addresses.
- **Single requester:** hold `req0_valid` with addr=3, data=0xA5 for 1 cycle in RUN. Required: `req0_ready`=1, `write_enable`=1 with `w_addr`=3 the following cycle, and `r_data0`@3 = 0xA5 one edge later.
- **Contention:** hold both valids for 4 cycles (req0 writes 0x10..0x13 to addr 0..3, req1 writes 0x20..0x23 to addr 4..7), and each requester advances only on its handshake. Required: grants go req0, req1, req0, req1, …, `prio` alternates, neither requester is starved, and all 8 words land correctly.
- **Clear collision:** assert `clear_req` together with `req1_valid`. Required: `req1_ready`=0 and no write issued for req1, `init_done` falls, then 8 zero-writes occur; req1 is accepted only after `init_done` returns.
- **Reset mid-clear:** assert `rst` when `w_addr`=5 during CLEAR. Required: all outputs go to their reset values and the sequence restarts at address 0, giving 8 full writes.
- **Back-to-back lone requester:** req1 alone is valid for 3 consecutive cycles, with `prio`=1 left over from an earlier req0 handshake. Required: 3 writes on 3 consecutive cycles with no bubble.
